// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS unified-memory arbiter.
// Optional build macro: MEM_ARB_PERF_EN adds the per-port wait-cycle counters.
package mips_mem_pkg;

    // Default memory geometry
    localparam int unsigned AW_DEF   = 10;
    localparam int unsigned DW_DEF   = 32;

    // Latency counter covers RD_LAT-1 for RD_LAT in 1..4
    localparam int unsigned LAT_CW   = 2;

    // Starvation streak counter width (MAX_STREAK up to 15)
    localparam int unsigned STREAK_W = 4;

    // Response tracker states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Read owner tags
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Value loaded into the latency counter when a read is issued
    function automatic logic [LAT_CW-1:0] lat_load(input int unsigned rd_lat);
        return LAT_CW'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_arb_resp_tracker.sv
// Tracks the single outstanding memory read: counts down the read latency
// and remembers which port owns the returning data.
module mem_arb_resp_tracker
    import mips_mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_start,
    input  logic start_owner,
    output logic busy_c,
    output logic resp_c,
    output logic resp_owner
);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [LAT_CW-1:0] cnt_q;
    logic [LAT_CW-1:0] cnt_d;
    logic              owner_q;
    logic              owner_d;

    // State, counter and owner registers; reset discards any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_I;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    // Next state: load on a read issue, count down, chain a new read in the response cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    state_d = ST_WAIT;
                    cnt_d   = lat_load(RD_LAT);
                    owner_d = start_owner;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_CW'(1);
                end else if (rd_start) begin
                    cnt_d   = lat_load(RD_LAT);
                    owner_d = start_owner;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_c     = (state_q == ST_WAIT);
    assign resp_c     = (state_q == ST_WAIT) && (cnt_q == '0);
    assign resp_owner = owner_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between the
// instruction-fetch port and the load/store port of the MIPS32 core.
// Optional build macro: MEM_ARB_PERF_EN adds i_wait_cnt / d_wait_cnt outputs.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [15:0]   i_wait_cnt,
    output logic [15:0]   d_wait_cnt,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic                busy_c;
    logic                resp_c;
    logic                resp_owner;
    logic                slot_c;
    logic                d_win_c;
    logic                i_win_c;
    logic                rd_start_c;
    logic                start_owner_c;
    logic [STREAK_W-1:0] streak_q;

    mem_arb_resp_tracker #(
        .RD_LAT (RD_LAT)
    ) u_resp (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_start    (rd_start_c),
        .start_owner (start_owner_c),
        .busy_c      (busy_c),
        .resp_c      (resp_c),
        .resp_owner  (resp_owner)
    );

    // Arbitration slot and winner selection; D is favoured until the streak limit
    always_comb begin
        slot_c  = !busy_c || resp_c;
        d_win_c = rst_n && slot_c && d_req && (streak_q < STREAK_MAX);
        i_win_c = rst_n && slot_c && i_req && (!d_req || (streak_q == STREAK_MAX));
    end

    assign i_gnt         = i_win_c;
    assign d_gnt         = d_win_c;
    assign rd_start_c    = i_win_c || (d_win_c && !d_we);
    assign start_owner_c = d_win_c ? OWN_D : OWN_I;

    // Memory drive comes straight from the winning requester
    always_comb begin
        mem_en    = i_win_c || d_win_c;
        mem_we    = d_win_c && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_win_c) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_win_c) begin
            mem_addr  = i_addr;
        end
    end

    // Response steering: only the recorded owner sees data
    always_comb begin
        i_rvalid = rst_n && resp_c && (resp_owner == OWN_I);
        d_rvalid = rst_n && resp_c && (resp_owner == OWN_D);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

    // Consecutive D grants while I is waiting; saturating, cleared when I is served or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (!i_req || i_win_c) begin
            streak_q <= '0;
        end else if (d_win_c && (streak_q < STREAK_MAX)) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Saturating counts of cycles each port spends stalled on a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_wait_cnt <= '0;
            d_wait_cnt <= '0;
        end else begin
            if (i_req && !i_win_c && (i_wait_cnt != 16'hFFFF)) begin
                i_wait_cnt <= i_wait_cnt + 16'd1;
            end
            if (d_req && !d_win_c && (d_wait_cnt != 16'hFFFF)) begin
                d_wait_cnt <= d_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3.
module tb_mips_mem_arbiter;

    logic clk;
    logic rst_n;

    // Instance with RD_LAT=1
    logic        i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic [9:0]  i_addr, d_addr, mem_addr;
    logic [31:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;

    // Instance with RD_LAT=3
    logic        i3_req, i3_gnt, i3_rvalid, d3_req, d3_we, d3_gnt, d3_rvalid;
    logic [9:0]  i3_addr, d3_addr, mem3_addr;
    logic [31:0] i3_rdata, d3_rdata, d3_wdata, mem3_wdata, mem3_rdata;
    logic        mem3_en, mem3_we;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] i_wc, d_wc, i3_wc, d3_wc;
`endif

    int n_total = 0;
    int n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_mem_arbiter #(.AW(10), .DW(32), .RD_LAT(1), .MAX_STREAK(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MEM_ARB_PERF_EN
        .i_wait_cnt(i_wc), .d_wait_cnt(d_wc),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mips_mem_arbiter #(.AW(10), .DW(32), .RD_LAT(3), .MAX_STREAK(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
`ifdef MEM_ARB_PERF_EN
        .i_wait_cnt(i3_wc), .d_wait_cnt(d3_wc),
`endif
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr),
        .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
    );

    // Initial memory image: a fixed function of the address
    function automatic logic [31:0] memval(input int a);
        return 32'h1000_0000 + 32'(a) * 32'h0001_0003;
    endfunction

    // Memory model: written words override the initial image
    bit   [1023:0] wr_vld;
    logic [31:0]   wmem [1024];
    logic [31:0]   p1;
    logic [31:0]   p3 [3];

    function automatic logic [31:0] rd(input logic [9:0] a);
        return wr_vld[a] ? wmem[a] : memval(int'(a));
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr]   <= mem_wdata;
            wr_vld[mem_addr] <= 1'b1;
        end
        p1    <= rd(mem_addr);
        p3[0] <= rd(mem3_addr);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign mem_rdata  = p1;
    assign mem3_rdata = p3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = '0; d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i3_req = 1'b0; i3_addr = '0; d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;

        // Reset: outputs forced low despite pending requests
        step(); #1;
        check("rst_i_gnt", 32'(i_gnt), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 0);

        // I-only fetch stream over addresses 0..7
        for (int k = 0; k < 9; k++) begin
            step();
            rst_n = 1'b1; d_req = 1'b0;
            i_req = (k < 8); i_addr = 10'(k);
            #1;
            check("fetch_i_gnt", 32'(i_gnt), 32'(k < 8));
            if (k < 8) check("fetch_addr", 32'(mem_addr), 32'(k));
            check("fetch_i_rvalid", 32'(i_rvalid), 32'(k >= 1));
            if (k >= 1) check("fetch_i_rdata", i_rdata, memval(k - 1));
            check("fetch_d_quiet", {d_rdata[29:0], d_gnt, d_rvalid}, 0);
        end

        // Simultaneous I and D load: D first, then I
        step();
        i_req = 1'b1; i_addr = 10'd50; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd100;
        #1;
        check("sim_d_gnt", 32'({i_gnt, d_gnt}), 32'b01);
        check("sim_mem_addr", 32'(mem_addr), 100);
        step();
        d_req = 1'b0;
        #1;
        check("sim_i_gnt", 32'({i_gnt, d_gnt}), 32'b10);
        check("sim_d_rvalid", 32'({i_rvalid, d_rvalid}), 32'b01);
        check("sim_d_rdata", d_rdata, memval(100));
        check("sim_i_rdata_zero", i_rdata, 0);
        step();
        i_req = 1'b0;
        #1;
        check("sim_i_rvalid", 32'({i_rvalid, d_rvalid}), 32'b10);
        check("sim_i_rdata", i_rdata, memval(50));

        // Starvation limit: four D grants then one I grant, repeating
        for (int j = 0; j < 10; j++) begin
            step();
            i_req = 1'b1; i_addr = 10'd200; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd300;
            #1;
            check("streak_gnt", 32'({i_gnt, d_gnt}), (j % 5 == 4) ? 32'b10 : 32'b01);
            if (j >= 1) check("streak_d_rvalid", 32'(d_rvalid), 32'((j - 1) % 5 != 4));
        end
        step();
        i_req = 1'b0; d_req = 1'b0;
        #1;
        check("streak_last_i", 32'({i_rvalid, d_rvalid}), 32'b10);
        check("streak_last_data", i_rdata, memval(200));

        // Store then load of the same word
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd20; d_wdata = 32'hDEADBEEF;
        #1;
        check("st_gnt", 32'(d_gnt), 1);
        check("st_mem", 32'({mem_en, mem_we}), 32'b11);
        check("st_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        d_we = 1'b0; d_wdata = '0;
        #1;
        check("ld_mem_we", 32'({mem_en, mem_we}), 32'b10);
        check("st_no_rvalid", 32'(d_rvalid), 0);
        step();
        d_req = 1'b0;
        #1;
        check("ld_rvalid", 32'(d_rvalid), 1);
        check("ld_rdata", d_rdata, 32'hDEADBEEF);

        // Top-of-range fetch: address passes through unmodified
        step();
        i_req = 1'b1; i_addr = 10'h3FF;
        #1;
        check("top_addr", 32'(mem_addr), 32'h3FF);
        step();
        i_req = 1'b0;
        #1;
        check("top_rdata", i_rdata, memval(1023));

        // RD_LAT=3: D waits through the latency and is granted in the response cycle
        step();
        i3_req = 1'b1; i3_addr = 10'd10;
        #1;
        check("l3_i_gnt", 32'(i3_gnt), 1);
        for (int m = 1; m < 7; m++) begin
            step();
            i3_req = 1'b0;
            d3_req = (m <= 3); d3_we = 1'b0; d3_addr = 10'd11;
            #1;
            check("l3_d_gnt", 32'(d3_gnt), 32'(m == 3));
            check("l3_i_rvalid", 32'(i3_rvalid), 32'(m == 3));
            if (m == 3) check("l3_i_rdata", i3_rdata, memval(10));
            check("l3_d_rvalid", 32'(d3_rvalid), 32'(m == 6));
            if (m == 6) check("l3_d_rdata", d3_rdata, memval(11));
        end

        // Reset one cycle into a RD_LAT=3 read discards it
        step();
        i3_req = 1'b1; i3_addr = 10'd5;
        #1;
        check("rr_i_gnt", 32'(i3_gnt), 1);
        step();
        i3_req = 1'b0; d3_req = 1'b1; d3_addr = 10'd7; rst_n = 1'b0;
        #1;
        check("rr_outputs_zero", 32'({i3_gnt, d3_gnt, mem3_en, i3_rvalid, d3_rvalid}), 0);
        for (int n = 0; n < 3; n++) begin
            step();
            rst_n = 1'b1; d3_req = 1'b0;
            #1;
            check("rr_no_rvalid", 32'({i3_rvalid, d3_rvalid}), 0);
        end
        step();
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 10'd7;
        #1;
        check("rr_first_gnt", 32'(d3_gnt), 1);
        for (int n = 1; n < 4; n++) begin
            step();
            d3_req = 1'b0;
            #1;
            check("rr_d_rvalid", 32'(d3_rvalid), 32'(n == 3));
            if (n == 3) check("rr_d_rdata", d3_rdata, memval(7));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
